evolved_circuit_evaluator: RTL and testbench
============================================

Name: evolved_circuit_evaluator

Overview:
- Stimulus and measurement stage wrapped around one evolved-circuit instance (2-bit input, 1-bit output, LCELL feedback loops, possibly oscillating).
- Drives `circuit_in` through all four combinations (00, 01, 10, 11) in that order.
- For each vector: waits a settle window, then samples the synchronised `circuit_out` over a sample window, counting high samples and transitions.
- Produces a 4-entry measured truth table plus per-vector oscillation flags for the fitness/reporting logic downstream.

Parameters:
- SETTLE_CYCLES, 16, clocks between applying a vector and starting to sample; legal range >= 3 (covers synchroniser latency).
- SAMPLE_CYCLES, 256, clocks sampled per vector; legal range >= 1.
- CNT_W, 9, width of the high and toggle counters; counters saturate at 2^CNT_W-1.
- OSC_THRESH, 2, toggle count at or above which a vector is flagged oscillating.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin an evaluation run; sampled only in IDLE
- circuit_in  out  2  stimulus to the evolved circuit's `in[1:0]`
- circuit_out  in  1  evolved circuit's output; asynchronous to clk
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when all four vectors have been measured
- rd_sel  in  2  vector index for result readout
- rd_high_count  out  CNT_W  high-sample count for vector `rd_sel` (combinational mux)
- rd_toggle_count  out  CNT_W  transition count for vector `rd_sel` (combinational mux)
- truth_table  out  4  bit k = 1 iff high_count[k] > SAMPLE_CYCLES/2
- oscillating  out  4  bit k = 1 iff toggle_count[k] >= OSC_THRESH

Behaviour:
- Reset (async assert, synchronous release): state IDLE; circuit_in = 0; busy = 0; done = 0; all counters 0; truth_table = 0; oscillating = 0; synchroniser flops 0.
- Synchroniser: circuit_out passes through 2 flops → `s`. A 1-flop delayed copy gives `s_prev`. A toggle is `s != s_prev`.
- FSM states: IDLE, SETTLE, SAMPLE, NEXT, FINISH.
- IDLE:
  - start = 1 → clear all eight counters, vec = 0, circuit_in = 0, go to SETTLE.
  - busy rises in the following cycle.
  - start is ignored in every other state.
- SETTLE:
  - Hold circuit_in = vec for exactly SETTLE_CYCLES clocks, then go to SAMPLE.
  - Nothing is counted.
- SAMPLE (exactly SAMPLE_CYCLES clocks):
  - Each cycle: if s = 1, increment high[vec]; if s != s_prev, increment toggle[vec].
  - Both counters are saturating and may increment in the same cycle.
  - The first cycle's s_prev comes from the last SETTLE cycle, so a transition across that boundary is counted.
- NEXT (1 clock):
  - vec = 3 → FINISH.
  - Otherwise vec++, circuit_in updates to the new vec, go to SETTLE.
- FINISH (1 clock): done = 1, busy = 0 from the next cycle, return to IDLE.
- Per-vector timing: SETTLE_CYCLES + SAMPLE_CYCLES + 1 clocks.
  - Full run, accepted start to done pulse: 4·(SETTLE_CYCLES + SAMPLE_CYCLES + 1) + 1 clocks.
  - Default run: 1093 clocks.
- truth_table and oscillating:
  - Combinational from the counters.
  - Meaningful only after done; hold until the next accepted start clears them.
- Saturation: with SAMPLE_CYCLES >= 2^CNT_W, counts stick at the max value and never wrap.
- Reset mid-run: immediate return to the reset state; partial results are discarded; no done pulse.
- Simultaneous start and done: impossible, since start is only sampled in IDLE. A start held high through FINISH launches a new run on the first IDLE cycle.

Decomposition:
- Shared package (evaluator_pkg):
  - state enum {IDLE, SETTLE, SAMPLE, NEXT, FINISH};
  - NUM_VECTORS = 4;
  - VEC_W = 2.
- Sub-module: sync_2ff (generic 2-flop synchroniser, async active-high reset, reset value 0). The rest is a single module.
- The evolved circuit is instantiated by the integrating top level, not inside this block.

Test Plan:
- AND stub (circuit_out = in[0] & in[1]), defaults → done after 1093 clocks; high counts 0,0,0,256; toggles 0,0,0,0; truth_table = 4'b1000; oscillating = 0.
- Stub toggling every clock when in = 2'b10, else 0 → toggle[2] = 255 or 256 (boundary-dependent, must match the model); high[2] = 128 ± 1; oscillating = 4'b0100; truth_table[2] = 0.
- Stub with output delayed 10 clocks after input change (XOR) → settle absorbs the delay; truth_table = 4'b0110; all toggle counts 0.
- CNT_W = 4, constant-1 stub → every high count saturates at 15 with no wrap; truth_table = 4'b0000, since 15 is not > 128.
- Reset asserted mid-SAMPLE of vector 1 → same cycle: circuit_in = 0, busy = 0, counters 0; no done pulse. A new start then gives a normal full run.
- start pulsed while busy → ignored; exactly one done pulse per accepted start; rd_sel sweep returns the stored counts unchanged.

Source files
------------

// File: rtl/evaluator_pkg.sv
// Shared types and sizing for the evolved-circuit evaluator.
// The state enum is shared so that checkers and wrappers decode the same encoding.
package evaluator_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4
  } state_e;

  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level.
// Both stages reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/evolved_circuit_evaluator.sv
// Steps an evolved circuit through all four input vectors and measures its output:
// high-sample and transition counts per vector, plus derived truth table and oscillation flags.
module evolved_circuit_evaluator
  import evaluator_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 256,
  parameter int CNT_W         = 9,
  parameter int OSC_THRESH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [VEC_W-1:0]       circuit_in,
  input  logic                   circuit_out,
  output logic                   busy,
  output logic                   done,
  input  logic [VEC_W-1:0]       rd_sel,
  output logic [CNT_W-1:0]       rd_high_count,
  output logic [CNT_W-1:0]       rd_toggle_count,
  output logic [NUM_VECTORS-1:0] truth_table,
  output logic [NUM_VECTORS-1:0] oscillating
);

  localparam int PHASE_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int PH_W      = $clog2(PHASE_MAX) + 1;
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  SAMPLE_LAST = PH_W'(SAMPLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [31:0]      HALF_SAMPLES = 32'(SAMPLE_CYCLES / 2);
  localparam logic [31:0]      OSC_LIMIT    = 32'(OSC_THRESH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PH_W-1:0]  r_phase;
  logic [VEC_W-1:0] r_vec;
  logic [VEC_W-1:0] r_circuit_in;
  logic             r_busy;
  logic             r_done;
  logic             w_s;
  logic             r_s_prev;
  logic             w_accept;
  logic             w_phase_end;
  logic [CNT_W-1:0] r_high   [NUM_VECTORS];
  logic [CNT_W-1:0] r_toggle [NUM_VECTORS];

  sync_2ff u_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (circuit_out),
    .o_q   (w_s)
  );

  // Next-state decode; start is only honoured in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_phase_end = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SETTLE;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (r_phase == SETTLE_LAST) begin
          w_state_nxt = SAMPLE;
          w_phase_end = 1'b1;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
      SAMPLE: begin
        if (r_phase == SAMPLE_LAST) begin
          w_state_nxt = NEXT;
          w_phase_end = 1'b1;
        end else begin
          w_state_nxt = SAMPLE;
        end
      end
      NEXT:    w_state_nxt = (r_vec == VEC_LAST) ? FINISH : SETTLE;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase timer, vector index, stimulus and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase      <= {PH_W{1'b0}};
      r_vec        <= {VEC_W{1'b0}};
      r_circuit_in <= {VEC_W{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_s_prev     <= 1'b0;
    end else begin
      r_s_prev <= w_s;
      r_done   <= (r_state == NEXT) && (r_vec == VEC_LAST);
      case (r_state)
        IDLE: begin
          r_phase <= {PH_W{1'b0}};
          if (start) begin
            r_vec        <= {VEC_W{1'b0}};
            r_circuit_in <= {VEC_W{1'b0}};
            r_busy       <= 1'b1;
          end
        end
        SETTLE, SAMPLE: r_phase <= w_phase_end ? {PH_W{1'b0}} : r_phase + PH_W'(1);
        NEXT: begin
          if (r_vec != VEC_LAST) begin
            r_vec        <= r_vec + VEC_W'(1);
            r_circuit_in <= r_vec + VEC_W'(1);
          end
        end
        FINISH:  r_busy <= 1'b0;
        default: r_phase <= {PH_W{1'b0}};
      endcase
    end
  end

  // Saturating per-vector counters; the first SAMPLE cycle compares against the last SETTLE value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_VECTORS; k++) begin
        r_high[k]   <= {CNT_W{1'b0}};
        r_toggle[k] <= {CNT_W{1'b0}};
      end
    end else if (w_accept) begin
      for (int k = 0; k < NUM_VECTORS; k++) begin
        r_high[k]   <= {CNT_W{1'b0}};
        r_toggle[k] <= {CNT_W{1'b0}};
      end
    end else if (r_state == SAMPLE) begin
      if (w_s && (r_high[r_vec] != CNT_MAX)) begin
        r_high[r_vec] <= r_high[r_vec] + CNT_W'(1);
      end
      if ((w_s != r_s_prev) && (r_toggle[r_vec] != CNT_MAX)) begin
        r_toggle[r_vec] <= r_toggle[r_vec] + CNT_W'(1);
      end
    end
  end

  // Derived classification of the stored counts
  always_comb begin
    truth_table = {NUM_VECTORS{1'b0}};
    oscillating = {NUM_VECTORS{1'b0}};
    for (int k = 0; k < NUM_VECTORS; k++) begin
      truth_table[k] = (32'(r_high[k]) > HALF_SAMPLES);
      oscillating[k] = (32'(r_toggle[k]) >= OSC_LIMIT);
    end
  end

  assign circuit_in      = r_circuit_in;
  assign busy            = r_busy;
  assign done            = r_done;
  assign rd_high_count   = r_high[rd_sel];
  assign rd_toggle_count = r_toggle[rd_sel];

endmodule

// File: tb/tb_evolved_circuit_evaluator.sv
// Self-checking bench: behavioural stubs for the evolved circuit, a cycle-history model of the
// expected counts derived from the evaluation schedule, and directed plus randomized runs.
module tb_evolved_circuit_evaluator;

  localparam int S   = 16;
  localparam int P   = 256;
  localparam int VT  = S + P + 1;
  localparam int RUN = 4 * VT + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start2;
  logic [1:0] circuit_in, circuit_in2;
  logic       circuit_out = 1'b0;
  logic       busy, done, busy2, done2;
  logic [1:0] rd_sel, rd_sel2;
  logic [8:0] rd_high, rd_tog;
  logic [3:0] rd_high2, rd_tog2;
  logic [3:0] truth, osc, truth2, osc2;

  int   ncmp = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   ndone = 0;
  int   ndone2 = 0;
  int   mode = 0;
  int   pct [4];
  logic hist [0:32767];
  logic [9:0] dl = 10'd0;

  always #5 clk = ~clk;

  evolved_circuit_evaluator dut (
    .clk(clk), .reset(reset), .start(start), .circuit_in(circuit_in),
    .circuit_out(circuit_out), .busy(busy), .done(done), .rd_sel(rd_sel),
    .rd_high_count(rd_high), .rd_toggle_count(rd_tog),
    .truth_table(truth), .oscillating(osc)
  );

  evolved_circuit_evaluator #(.CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .circuit_in(circuit_in2),
    .circuit_out(1'b1), .busy(busy2), .done(done2), .rd_sel(rd_sel2),
    .rd_high_count(rd_high2), .rd_toggle_count(rd_tog2),
    .truth_table(truth2), .oscillating(osc2)
  );

  // Record the stub output seen at every rising edge and count done pulses
  always @(posedge clk) begin
    if (cyc < 32768) hist[cyc] <= circuit_out;
    cyc <= cyc + 1;
    if (done)  ndone  <= ndone + 1;
    if (done2) ndone2 <= ndone2 + 1;
  end

  // Evolved-circuit stubs, updated on the falling edge so the output is asynchronous to sampling
  always @(negedge clk) begin
    dl <= {dl[8:0], circuit_in[0] ^ circuit_in[1]};
    case (mode)
      0:       circuit_out <= circuit_in[0] & circuit_in[1];
      1:       circuit_out <= (circuit_in == 2'b10) ? ~circuit_out : 1'b0;
      2:       circuit_out <= dl[9];
      3:       circuit_out <= 1'b1;
      default: circuit_out <= (int'($urandom_range(0, 99)) < pct[circuit_in]);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // The synchronised value used at counting edge n is the output seen at edge n-2
  function automatic int model_high(input int a, input int k, input int cmax);
    int n0 = a + k * VT + S + 1;
    int c = 0;
    for (int n = n0; n < n0 + P; n++) c += int'(hist[n-2]);
    return (c > cmax) ? cmax : c;
  endfunction

  function automatic int model_tog(input int a, input int k, input int cmax);
    int n0 = a + k * VT + S + 1;
    int c = 0;
    for (int n = n0; n < n0 + P; n++) c += (hist[n-2] != hist[n-3]) ? 1 : 0;
    return (c > cmax) ? cmax : c;
  endfunction

  task automatic check_results(input string tag, input int a);
    int eh, et;
    logic [3:0] etruth, eosc;
    etruth = 4'b0000;
    eosc   = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      eh = model_high(a, k, 511);
      et = model_tog(a, k, 511);
      etruth[k] = (eh > P / 2);
      eosc[k]   = (et >= 2);
      rd_sel = 2'(k);
      #1;
      chk($sformatf("%s high[%0d]", tag, k), 32'(rd_high), 32'(eh));
      chk($sformatf("%s toggle[%0d]", tag, k), 32'(rd_tog), 32'(et));
    end
    chk({tag, " truth_table"}, 32'(truth), 32'(etruth));
    chk({tag, " oscillating"}, 32'(osc), 32'(eosc));
  endtask

  task automatic run_eval(input string tag, input int extra_starts, output int a);
    bit seen;
    int d0;
    @(posedge clk); #1;
    chk({tag, " busy idle"}, 32'(busy), 32'd0);
    start = 1'b1;
    a = cyc;
    d0 = ndone;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy after accept"}, 32'(busy), 32'd1);
    for (int j = 0; j < extra_starts; j++) begin
      repeat ($urandom_range(10, 250)) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < RUN + 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk({tag, " done seen"}, 32'(seen), 32'd1);
    if (seen) chk({tag, " run latency"}, 32'(cyc - a), 32'(RUN));
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " busy after done"}, 32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk({tag, " done pulses"}, 32'(ndone - d0), 32'd1);
    chk({tag, " stays idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int a;
    bit seen;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; rd_sel = 2'd0; rd_sel2 = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst circuit_in", 32'(circuit_in), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst truth", 32'(truth), 32'd0);
    chk("rst osc", 32'(osc), 32'd0);
    chk("rst high2", 32'(rd_high2), 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd_sel = 2'(k); #1;
      chk($sformatf("rst high[%0d]", k), 32'(rd_high), 32'd0);
      chk($sformatf("rst toggle[%0d]", k), 32'(rd_tog), 32'd0);
    end
    @(negedge clk) reset = 1'b0;

    mode = 0;
    run_eval("and", 0, a);
    check_results("and", a);
    chk("and truth const", 32'(truth), 32'b1000);
    chk("and osc const", 32'(osc), 32'd0);
    rd_sel = 2'd3; #1;
    chk("and high[3] const", 32'(rd_high), 32'd256);

    mode = 1;
    run_eval("tog", 0, a);
    check_results("tog", a);
    chk("tog osc const", 32'(osc), 32'b0100);
    chk("tog truth[2]", 32'(truth[2]), 32'd0);
    rd_sel = 2'd2; #1;
    chk("tog high[2] near half", 32'(rd_high >= 9'd127 && rd_high <= 9'd129), 32'd1);
    chk("tog toggle[2] range", 32'(rd_tog >= 9'd255), 32'd1);

    mode = 2;
    run_eval("xor_dly", 0, a);
    check_results("xor_dly", a);
    chk("xor_dly truth const", 32'(truth), 32'b0110);
    chk("xor_dly osc const", 32'(osc), 32'd0);

    mode = 4;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) pct[k] = int'($urandom_range(0, 100));
      run_eval($sformatf("rand%0d", r), 3, a);
      check_results($sformatf("rand%0d", r), a);
      check_results($sformatf("rand%0d reread", r), a);
    end

    mode = 3;
    @(posedge clk); #1 start = 1'b1;
    a = cyc;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < a + VT + S + 50) begin
      @(posedge clk); #1;
    end
    chk("midrst in vec1", 32'(circuit_in), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst circuit_in", 32'(circuit_in), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst truth", 32'(truth), 32'd0);
    for (int k = 0; k < 2; k++) begin
      rd_sel = 2'(k); #1;
      chk($sformatf("midrst high[%0d]", k), 32'(rd_high), 32'd0);
    end
    @(negedge clk) reset = 1'b0;
    a = ndone;
    repeat (RUN + 20) @(posedge clk);
    #1;
    chk("midrst no done", 32'(ndone - a), 32'd0);
    chk("midrst idle", 32'(busy), 32'd0);
    mode = 0;
    run_eval("after_rst", 0, a);
    check_results("after_rst", a);

    @(posedge clk); #1 start2 = 1'b1;
    a = cyc;
    @(posedge clk); #1 start2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < RUN + 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (done2) seen = 1'b1;
    end
    chk("sat done seen", 32'(seen), 32'd1);
    if (seen) chk("sat latency", 32'(cyc - a), 32'(RUN));
    for (int k = 0; k < 4; k++) begin
      rd_sel2 = 2'(k); #1;
      chk($sformatf("sat high[%0d]", k), 32'(rd_high2), 32'((P > 15) ? 15 : P));
      chk($sformatf("sat toggle[%0d]", k), 32'(rd_tog2), 32'd0);
    end
    chk("sat truth", 32'(truth2), 32'd0);
    chk("sat osc", 32'(osc2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
